// File: rtl/hack_memory_pkg.sv
// Shared memory-map constants for the Hack CPU and its data memory.
// Region limits, the keyboard register address, the key FIFO depth,
// and a decode helper that maps a word address to its region.
package hack_memory_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RAM_AW = 14;
    localparam int unsigned SCR_AW = 13;

    localparam logic [ADDR_W-1:0] RAM_BASE     = 15'h0000;
    localparam logic [ADDR_W-1:0] RAM_LIMIT    = 15'h3FFF;
    localparam logic [ADDR_W-1:0] SCREEN_BASE  = 15'h4000;
    localparam logic [ADDR_W-1:0] SCREEN_LIMIT = 15'h5FFF;
    localparam logic [ADDR_W-1:0] KBD_ADDR     = 15'h6000;

    localparam int unsigned KBD_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        REGION_RAM     = 2'd0,
        REGION_SCREEN  = 2'd1,
        REGION_KBD     = 2'd2,
        REGION_ILLEGAL = 2'd3
    } region_e;

    // Everything above KBD_ADDR up to the top of the 15-bit space is a hole.
    function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
        region_e r;
        if (addr <= RAM_LIMIT) begin
            r = REGION_RAM;
        end else if (addr <= SCREEN_LIMIT) begin
            r = REGION_SCREEN;
        end else if (addr == KBD_ADDR) begin
            r = REGION_KBD;
        end else begin
            r = REGION_ILLEGAL;
        end
        return r;
    endfunction

endpackage

// File: rtl/hack_memory_key_fifo.sv
// Small key-event FIFO. The head is visible combinationally (0 when empty)
// so the CPU can peek the keyboard register without consuming it.
// ready is driven from pre-edge occupancy; when full, a push is still
// taken on an edge that also pops, keeping occupancy at DEPTH.
module key_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic             ready,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign ready   = (count != FULL_CNT);
    assign do_pop  = pop_req && !empty;
    assign do_push = push_valid && (ready || do_pop);
    assign head    = empty ? '0 : slots[rd_ptr];

    // Storage write; nothing lands while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (a power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hack_memory.sv
// Hack data memory: 16K RAM, 8K screen buffer and a keyboard register
// backed by a small key FIFO. Reads are combinational so the CPU sees inM
// in the same cycle it drives addressM. Screen writes are mirrored out as
// a one-cycle notification for a display engine. Writes into the address
// hole are dropped and raise a sticky error flag.
module hack_memory
    import hack_memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    input  logic              kbd_valid,
    input  logic [DATA_W-1:0] kbd_data,
    output logic              kbd_ready,
    output logic              scr_we,
    output logic [SCR_AW-1:0] scr_addr,
    output logic [DATA_W-1:0] scr_data,
    output logic              err
);

    localparam int unsigned RAM_WORDS    = 1 << RAM_AW;
    localparam int unsigned SCREEN_WORDS = 1 << SCR_AW;

    logic [DATA_W-1:0] ram    [RAM_WORDS];
    logic [DATA_W-1:0] screen [SCREEN_WORDS];

    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;
    logic              ram_wr;
    logic              scr_wr;
    logic              kbd_ack;
    logic              bad_wr;
    logic [DATA_W-1:0] kbd_head;

    assign region  = decode_region(address);
    assign ram_idx = RAM_AW'(address - RAM_BASE);
    assign scr_idx = SCR_AW'(address - SCREEN_BASE);
    assign ram_wr  = load && (region == REGION_RAM);
    assign scr_wr  = load && (region == REGION_SCREEN);
    assign kbd_ack = load && (region == REGION_KBD);
    assign bad_wr  = load && (region == REGION_ILLEGAL);

    key_fifo #(
        .DEPTH (KBD_FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_key_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (kbd_valid),
        .push_data  (kbd_data),
        .pop_req    (kbd_ack),
        .ready      (kbd_ready),
        .head       (kbd_head)
    );

    // RAM array: contents survive reset, but a write on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && ram_wr) begin
            ram[ram_idx] <= in;
        end
    end

    // Screen array: same retention and reset-edge rule as RAM.
    always_ff @(posedge clk) begin
        if (rst_n && scr_wr) begin
            screen[scr_idx] <= in;
        end
    end

    // Combinational read mux; holes and reads during a write return pre-edge data.
    always_comb begin
        out = '0;
        case (region)
            REGION_RAM:    out = ram[ram_idx];
            REGION_SCREEN: out = screen[scr_idx];
            REGION_KBD:    out = kbd_head;
            default:       out = '0;
        endcase
    end

    // One-cycle screen write notification for the display side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_we   <= 1'b0;
            scr_addr <= '0;
            scr_data <= '0;
        end else begin
            scr_we <= scr_wr;
            if (scr_wr) begin
                scr_addr <= scr_idx;
                scr_data <= in;
            end
        end
    end

    // Sticky flag for writes into the unmapped region.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (bad_wr) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hack_memory.sv
// Scoreboard bench for hack_memory. The driver applies one bus cycle at a
// time, queues the expected read/ready/err view for that cycle and any
// expected screen notification, then advances a queue-based memory-map model.
// A monitor on the falling edge pops and compares independently.
module tb_hack_memory;

    logic        clk;
    logic        rst_n;
    logic [15:0] wdata;
    logic        load;
    logic [14:0] address;
    logic [15:0] rdata;
    logic        kbd_valid;
    logic [15:0] kbd_data;
    logic        kbd_ready;
    logic        scr_we;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        err;

    hack_memory dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (wdata),
        .load      (load),
        .address   (address),
        .out       (rdata),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .kbd_ready (kbd_ready),
        .scr_we    (scr_we),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk_out;
        logic [15:0] out;
        logic        ready;
        logic        err;
    } exp_t;

    typedef struct {
        logic [12:0] a;
        logic [15:0] d;
    } scr_t;

    exp_t        exp_q[$];
    scr_t        scr_q[$];

    logic [15:0] m_ram [int];
    logic [15:0] m_scr [int];
    logic [15:0] kq[$];
    bit          m_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [14:0] ram_pool [4] = '{15'h0000, 15'h0005, 15'h1234, 15'h3FFF};
    logic [14:0] scr_pool [4] = '{15'h4000, 15'h4010, 15'h4ABC, 15'h5FFF};
    logic [14:0] bad_pool [3] = '{15'h6001, 15'h7000, 15'h7FFF};

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, req);
    endfunction

    // Reference read: memory map by address range; unwritten words are unknown.
    function automatic void model_read(input logic [14:0] a, output bit known, output logic [15:0] v);
        known = 1'b1;
        v     = 16'h0000;
        if (a <= 15'h3FFF) begin
            known = m_ram.exists(int'(a));
            if (known) v = m_ram[int'(a)];
        end else if (a <= 15'h5FFF) begin
            known = m_scr.exists(int'(a));
            if (known) v = m_scr[int'(a)];
        end else if (a == 15'h6000) begin
            if (kq.size() > 0) v = kq[0];
        end
    endfunction

    task automatic step(input logic ld, input logic [14:0] a, input logic [15:0] d,
                        input logic kv, input logic [15:0] kd);
        exp_t        e;
        scr_t        s;
        bit          known;
        logic [15:0] v;
        logic [15:0] junk;
        @(posedge clk);
        #1;
        load = ld; address = a; wdata = d; kbd_valid = kv; kbd_data = kd;
        model_read(a, known, v);
        e.chk_out = known;
        e.out     = v;
        e.ready   = (kq.size() < 4);
        e.err     = m_err;
        exp_q.push_back(e);
        if (ld) begin
            if (a <= 15'h3FFF) begin
                m_ram[int'(a)] = d;
            end else if (a <= 15'h5FFF) begin
                m_scr[int'(a)] = d;
                s.a = a[12:0];
                s.d = d;
                scr_q.push_back(s);
            end else if (a == 15'h6000) begin
                if (kq.size() > 0) junk = kq.pop_front();
            end else begin
                m_err = 1'b1;
            end
        end
        if (kv && kq.size() < 4) kq.push_back(kd);
    endtask

    // Reset held across exactly one rising edge carrying the given bus cycle.
    task automatic reset_pulse(input logic ld, input logic [14:0] a, input logic [15:0] d, input logic kv);
        exp_t        e;
        bit          known;
        logic [15:0] v;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        load = ld; address = a; wdata = d; kbd_valid = kv; kbd_data = 16'h00EE;
        kq.delete();
        scr_q.delete();
        m_err = 1'b0;
        model_read(a, known, v);
        e.chk_out = known;
        e.out     = v;
        e.ready   = 1'b1;
        e.err     = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load = 1'b0; kbd_valid = 1'b0;
    endtask

    // Monitor: compare the queued view each cycle and every screen notification.
    initial begin
        exp_t e;
        scr_t s;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_out) chk("out", rdata, e.out);
                chk("kbd_ready", {15'b0, kbd_ready}, {15'b0, e.ready});
                chk("err", {15'b0, err}, {15'b0, e.err});
            end
            if (scr_we === 1'b1) begin
                if (scr_q.size() == 0) begin
                    chk("scr_we_unexpected", {15'b0, scr_we}, 16'h0000);
                end else begin
                    s = scr_q.pop_front();
                    chk("scr_addr", {3'b0, scr_addr}, {3'b0, s.a});
                    chk("scr_data", scr_data, s.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel;
        logic [14:0] a;
        rst_n = 1'b1; load = 1'b0; address = 15'h6000; wdata = 16'h0000;
        kbd_valid = 1'b0; kbd_data = 16'h0000;

        reset_pulse(1'b0, 15'h6000, 16'h0000, 1'b0);

        // RAM write, read-during-write returns old data, then new data.
        step(1'b1, 15'h0005, 16'hAAAA, 1'b0, 16'h0);
        step(1'b1, 15'h0005, 16'h1234, 1'b0, 16'h0);
        step(1'b0, 15'h0005, 16'h0000, 1'b0, 16'h0);
        step(1'b0, 15'h0005, 16'h0000, 1'b0, 16'h0);

        // Screen write notification and readback.
        step(1'b1, 15'h4010, 16'hFFFF, 1'b0, 16'h0);
        step(1'b0, 15'h4010, 16'h0000, 1'b0, 16'h0);
        step(1'b0, 15'h4010, 16'h0000, 1'b0, 16'h0);

        // Fill the key FIFO, offer a fifth key, then drain with acknowledges.
        for (int k = 0; k < 5; k++) step(1'b0, 15'h6000, 16'h0, 1'b1, 16'h0041 + 16'(k));
        step(1'b0, 15'h6000, 16'h0, 1'b0, 16'h0);
        for (int k = 0; k < 4; k++) step(1'b1, 15'h6000, 16'hBEEF, 1'b0, 16'h0);
        step(1'b0, 15'h6000, 16'h0, 1'b0, 16'h0);
        step(1'b1, 15'h6000, 16'h0, 1'b0, 16'h0);

        // Full FIFO with simultaneous push and acknowledge.
        for (int k = 0; k < 4; k++) step(1'b0, 15'h6000, 16'h0, 1'b1, 16'h0061 + 16'(k));
        step(1'b1, 15'h6000, 16'h0, 1'b1, 16'h0070);
        step(1'b0, 15'h6000, 16'h0, 1'b0, 16'h0);
        step(1'b0, 15'h6000, 16'h0, 1'b0, 16'h0);

        // Illegal write: ignored, err sticky, hole reads as zero.
        step(1'b1, 15'h7000, 16'h5555, 1'b0, 16'h0);
        step(1'b0, 15'h7000, 16'h0000, 1'b0, 16'h0);
        step(1'b0, 15'h0005, 16'h0000, 1'b0, 16'h0);
        step(1'b0, 15'h6000, 16'h0000, 1'b0, 16'h0);

        // Reset mid-stream with keys queued and an in-flight RAM write.
        reset_pulse(1'b1, 15'h0005, 16'hDEAD, 1'b1);
        step(1'b0, 15'h6000, 16'h0, 1'b0, 16'h0);
        step(1'b0, 15'h0005, 16'h0, 1'b0, 16'h0);
        for (int k = 0; k < 2; k++) step(1'b0, 15'h6000, 16'h0, 1'b1, 16'h0030 + 16'(k));
        step(1'b1, 15'h4000, 16'h0F0F, 1'b0, 16'h0);
        reset_pulse(1'b0, 15'h6000, 16'h0, 1'b0);
        step(1'b0, 15'h0005, 16'h0, 1'b0, 16'h0);

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 19);
            if (sel < 8)       a = ram_pool[$urandom_range(0, 3)];
            else if (sel < 12) a = scr_pool[$urandom_range(0, 3)];
            else if (sel < 19) a = 15'h6000;
            else               a = bad_pool[$urandom_range(0, 2)];
            if ($urandom_range(0, 49) == 0)
                reset_pulse(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)));
            else
                step(1'($urandom_range(0, 1)), a, 16'($urandom),
                     1'($urandom_range(0, 1)), 16'($urandom));
        end

        step(1'b0, 15'h6000, 16'h0, 1'b0, 16'h0);
        step(1'b0, 15'h6000, 16'h0, 1'b0, 16'h0);
        @(negedge clk);
        #1;
        chk("exp_queue_drained", 16'(exp_q.size()), 16'h0000);
        chk("scr_pulses_missing", 16'(scr_q.size()), 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hack_memory.md
HACK_MEMORY -- requirements
Module: hack_memory

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-003 SHALL have port in, input, 16 bits: write data, driven from CPU outM.
REQ-004 SHALL have port load, input, 1 bit: write enable, driven from CPU writeM.
REQ-005 SHALL have port address, input, 15 bits: word address, driven from CPU addressM.
REQ-006 SHALL have port out, output, 16 bits: read data, driving CPU inM.
REQ-007 SHALL have port kbd_valid, input, 1 bit: a key event is offered.
REQ-008 SHALL have port kbd_data, input, 16 bits: key code of the offered event.
REQ-009 SHALL have port kbd_ready, output, 1 bit: the key FIFO can accept an event.
REQ-010 SHALL have port scr_we, output, 1 bit: a screen write notification is present.
REQ-011 SHALL have port scr_addr, output, 13 bits: screen word offset of that write.
REQ-012 SHALL have port scr_data, output, 16 bits: screen data of that write.
REQ-013 SHALL have port err, output, 1 bit: sticky illegal-access flag.

Function
REQ-014 SHALL decode address as follows: 0x0000-0x3FFF is RAM (16K x 16); 0x4000-0x5FFF is SCREEN (8K x 16); 0x6000 is KBD; 0x6001-0x7FFF is illegal.
REQ-015 SHALL make out a combinational function of address and current state, with zero-cycle read latency, matching the CPU's same-cycle use of inM.
REQ-016 SHALL, when load=1 and address is in RAM or SCREEN, write in at that location on the rising clk edge; a read of the same address in the same cycle SHALL return the old value.
REQ-017 SHALL, on each SCREEN write, register scr_we=1, scr_addr=address[12:0] and scr_data=in for exactly one cycle after the edge; otherwise scr_we=0.
REQ-018 SHALL implement the key FIFO with depth 4 and 16-bit width; kbd_ready=1 exactly when the FIFO is not full.
REQ-019 SHALL push kbd_data on an edge where kbd_valid=1 and kbd_ready=1; kbd_valid=1 while full SHALL be ignored, with no push and no error.
REQ-020 SHALL return the FIFO head on a KBD read, or 0x0000 when the FIFO is empty; reading SHALL NOT pop.
REQ-021 SHALL pop the FIFO head when load=1 and address=0x6000 (acknowledge), ignoring the data value; an acknowledge while empty SHALL be a no-op.
REQ-022 SHALL, on a simultaneous push and pop, perform both: occupancy is unchanged, and a push and pop while full SHALL be accepted because ready reflects pre-edge occupancy.
REQ-023 SHALL wrap the FIFO read/write pointers modulo 4 and keep a 3-bit count.
REQ-024 SHALL return 0x0000 on an illegal-address read; an illegal-address write SHALL be ignored and SHALL set err=1 at the next edge.
REQ-025 SHALL hold err at 1 until reset.

Reset
REQ-026 SHALL, on rst_n=0, immediately clear FIFO pointers and count, scr_we, scr_addr, scr_data and err; kbd_ready SHALL then be 1.
REQ-027 SHALL NOT reset RAM and SCREEN contents; after reset they are retained, or undefined at power-up.
REQ-028 SHALL, on a reset asserted mid-operation, drop any in-flight write or push on that edge and discard any pending scr_we pulse.

Structure
REQ-029 SHALL place the region base and limit constants, KBD_ADDR=0x6000 and KBD_FIFO_DEPTH=4 in the shared package used by the CPU.
REQ-030 SHALL implement the key FIFO as a sub-module key_fifo; decode, arrays and screen notification SHALL stay in hack_memory.

Verification
REQ-031 SHALL cover this scenario: write 0x1234 to 0x0005, then read 0x0005 -> out=0x1234 in the cycle after the write and 0xXXXX-free thereafter; reading 0x0005 in the write cycle returns the prior value.
REQ-032 SHALL cover this scenario: write 0xFFFF to 0x4010 -> scr_we=1, scr_addr=0x0010, scr_data=0xFFFF for one cycle, then scr_we=0; reading 0x4010 returns 0xFFFF.
REQ-033 SHALL cover this scenario: push 0x0041, 0x0042, 0x0043, 0x0044 -> kbd_ready=0; a fifth kbd_valid is ignored; a read of 0x6000 returns 0x0041; acknowledge then returns 0x0042; after four acknowledges the read returns 0x0000.
REQ-034 SHALL cover this scenario: with the FIFO full, assert push and acknowledge on the same edge -> count stays 4, and the head advances.
REQ-035 SHALL cover this scenario: write to 0x7000 -> no state change, err=1 from the next cycle and held; reading 0x7000 returns 0x0000; asserting rst_n=0 clears err asynchronously.
REQ-036 SHALL cover this scenario: assert rst_n mid-stream with 2 keys queued -> kbd_ready=1, KBD read returns 0x0000, and RAM[0x0005] still returns 0x1234.
